// File: rtl/npu_pkg.sv
// Shared widths, column layout and saturation helper for the NPU MAC final adder stage.
package npu_pkg;

  localparam int SUM_W    = 20;
  localparam int OUT_W    = 13;
  localparam int COL_IN_W = 56;
  localparam int COL_LO   = 3;
  localparam int COL_HI   = 19;

  localparam int SAT_MAX = 4095;
  localparam int SAT_MIN = -4096;

  localparam int COL_W_3   = 1;
  localparam int COL_W_4   = 2;
  localparam int COL_W_5   = 3;
  localparam int COL_W_6   = 3;
  localparam int COL_W_MID = 4;
  localparam int COL_W_17  = 3;
  localparam int COL_W_18  = 3;
  localparam int COL_W_19  = 1;

  typedef logic signed [OUT_W-1:0] act_t;

  function automatic int col_width(input int k);
    int w;
    case (k)
      3:       w = COL_W_3;
      4:       w = COL_W_4;
      5:       w = COL_W_5;
      6:       w = COL_W_6;
      17:      w = COL_W_17;
      18:      w = COL_W_18;
      19:      w = COL_W_19;
      default: w = COL_W_MID;
    endcase
    return w;
  endfunction

  // Columns are packed LSB first, so a column's offset is the total width of all lower columns.
  function automatic int col_offset(input int k);
    int off;
    off = 0;
    for (int j = COL_LO; j < k; j++) begin
      off += col_width(j);
    end
    return off;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // The two top sum bits disagreeing means the value does not fit the 13-bit window at weight 2^6.
  function automatic act_t saturate(input logic [SUM_W-1:0] s);
    act_t r;
    case (s[SUM_W-1 -: 2])
      2'b01:   r = act_t'(SAT_MAX);
      2'b10:   r = act_t'(SAT_MIN);
      default: r = act_t'(s[SUM_W-2 -: OUT_W]);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/addertree_final_column_sum.sv
// Combinational resolve of the stage2 column bits: popcount each column, weight it, add.
module column_sum
  import npu_pkg::*;
(
  input  logic [COL_IN_W-1:0] col_in,
  output logic [SUM_W-1:0]    sum
);

  logic [SUM_W-1:0] terms [COL_LO:COL_HI];

  for (genvar k = COL_LO; k <= COL_HI; k++) begin : g_col
    localparam int W   = col_width(k);
    localparam int OFF = col_offset(k);

    logic [3:0] bits;
    logic [2:0] ones;

    assign bits     = 4'(col_in[OFF +: W]);
    assign ones     = popcount4(bits);
    assign terms[k] = SUM_W'(ones) << k;
  end

  // Carries out of bit 19 fall off naturally in the 20-bit additions.
  assign sum = ((terms[3]  + terms[4])  + (terms[5]  + terms[6]))
             + ((terms[7]  + terms[8])  + (terms[9]  + terms[10]))
             + ((terms[11] + terms[12]) + (terms[13] + terms[14]))
             + ((terms[15] + terms[16]) + (terms[17] + terms[18]))
             + terms[19];

endmodule

// File: rtl/addertree_final.sv
// Final carry-propagate, saturation and accumulation-group sequencing of the MAC datapath.
// Optional build macro ADDERTREE_RELU_EN clamps negative group results to zero on out_data.
module addertree_final
  import npu_pkg::*;
#(
  parameter int ACC_LEN = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COL_IN_W-1:0] col_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                clear,
  output act_t                pre_output,
  output act_t                out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int CNT_W = (ACC_LEN > 2) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ACC_LEN - 1);

  logic [SUM_W-1:0] col_total;
  act_t             step_result;
  act_t             final_result;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_step;

  column_sum u_column_sum (
    .col_in (col_in),
    .sum    (col_total)
  );

  assign step_result = saturate(col_total);

`ifdef ADDERTREE_RELU_EN
  assign final_result = step_result[OUT_W-1] ? '0 : step_result;
`else
  assign final_result = step_result;
`endif

  // Stall input only while a finished result is held and not being drained this cycle.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == LAST_STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      pre_output <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // clear drops any step arriving with it but leaves the held output alone.
      if (clear) begin
        cnt        <= '0;
        pre_output <= '0;
      end else if (accept) begin
        if (last_step) begin
          out_data   <= final_result;
          out_valid  <= 1'b1;
          pre_output <= '0;
          cnt        <= '0;
        end else begin
          pre_output <= step_result;
          cnt        <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_addertree_final.sv
// Randomized scoreboard bench for addertree_final against a plain-arithmetic reference model.
module tb_addertree_final;

  localparam int ACC_LEN = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               clear;
  logic               in_valid;
  logic               out_ready;
  logic [55:0]        col_in;
  logic               in_ready;
  logic               out_valid;
  logic signed [12:0] pre_output;
  logic signed [12:0] out_data;

  always #5 clk = ~clk;

  addertree_final #(.ACC_LEN(ACC_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .col_in     (col_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .clear      (clear),
    .pre_output (pre_output),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  typedef struct {
    int pre;
    int od;
    bit ov;
    bit rdy;
  } state_t;

  state_t state_q[$];
  int     exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     m_cnt = 0;
  int     m_pre = 0;
  int     m_od  = 0;
  bit     m_ov  = 1'b0;
  bit     done  = 1'b0;

  function automatic int ref_width(input int k);
    if (k == 3 || k == 19) return 1;
    if (k == 4) return 2;
    if (k == 5 || k == 6 || k == 17 || k == 18) return 3;
    return 4;
  endfunction

  function automatic int ref_offset(input int k);
    int o;
    o = 0;
    for (int j = 3; j < k; j++) o += ref_width(j);
    return o;
  endfunction

  function automatic logic [55:0] col_bit(input int k, input int b);
    logic [55:0] one;
    one = 56'd1;
    return one << (ref_offset(k) + b);
  endfunction

  // Sum of each set bit's column weight, wrapped to 20 bits.
  function automatic int ref_sum(input logic [55:0] c);
    int s;
    logic [55:0] sh;
    s = 0;
    for (int k = 3; k <= 19; k++) begin
      for (int b = 0; b < ref_width(k); b++) begin
        sh = c >> (ref_offset(k) + b);
        if (sh[0]) s += (1 << k);
      end
    end
    return s & 32'h000F_FFFF;
  endfunction

  function automatic int ref_sat(input int s20);
    int top;
    int v;
    top = s20 >> 18;
    v = (s20 >> 6) & 32'h1FFF;
    if (v >= 4096) v -= 8192;
    if (top == 1) return 4095;
    if (top == 2) return -4096;
    return v;
  endfunction

  // Advances the model by the edge that just sampled the currently driven inputs.
  task automatic model_step();
    int r;
    int fin;
    bit rdy;
    if (reset) begin
      m_cnt = 0;
      m_pre = 0;
      m_od  = 0;
      m_ov  = 1'b0;
      exp_q.delete();
    end else begin
      rdy = !m_ov || out_ready;
      if (m_ov && out_ready) m_ov = 1'b0;
      if (clear) begin
        m_cnt = 0;
        m_pre = 0;
      end else if (in_valid && rdy) begin
        r = ref_sat(ref_sum(col_in));
        if (m_cnt == ACC_LEN - 1) begin
          fin = r;
`ifdef ADDERTREE_RELU_EN
          if (fin < 0) fin = 0;
`endif
          m_od  = fin;
          m_ov  = 1'b1;
          exp_q.push_back(fin);
          m_pre = 0;
          m_cnt = 0;
        end else begin
          m_pre = r;
          m_cnt = m_cnt + 1;
        end
      end
    end
  endtask

  task automatic apply_stimulus(input bit rst, input bit clr, input bit iv, input bit ord,
                                input logic [55:0] col);
    state_t st;
    @(posedge clk);
    #1;
    model_step();
    reset     = rst;
    clear     = clr;
    in_valid  = iv;
    out_ready = ord;
    col_in    = col;
    st.pre = m_pre;
    st.od  = m_od;
    st.ov  = m_ov;
    st.rdy = !m_ov || ord;
    state_q.push_back(st);
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic run_group(input logic [55:0] col);
    for (int i = 0; i < ACC_LEN; i++) apply_stimulus(0, 0, 1, 1, col);
  endtask

  // Monitor: compares presented state each cycle and pops the scoreboard on each output handshake.
  initial begin
    state_t st;
    while (!done) begin
      @(negedge clk);
      if (state_q.size() > 0) begin
        st = state_q.pop_front();
        check_output("pre_output", int'(pre_output), st.pre);
        check_output("out_valid", int'(out_valid), int'(st.ov));
        check_output("in_ready", int'(in_ready), int'(st.rdy));
        if (st.ov) check_output("out_data_held", int'(out_data), st.od);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL unexpected_output at %0t: got %0d expected none", $time, out_data);
          end else begin
            check_output("out_data", int'(out_data), exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [55:0] pat;
    logic [55:0] relu_pat;
    logic [55:0] sat_pats [4];
    int mode;

    reset = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    col_in = '0;

    sat_pats[0] = col_bit(18, 0);
    sat_pats[1] = col_bit(19, 0);
    sat_pats[2] = col_bit(18, 0) | col_bit(18, 1) | col_bit(18, 2);
    sat_pats[3] = col_bit(6, 0) | col_bit(8, 0);

    relu_pat = col_bit(19, 0) | col_bit(6, 0) | col_bit(7, 0);
    for (int k = 9; k <= 18; k++) relu_pat |= col_bit(k, 0);

    apply_stimulus(1, 0, 0, 1, '0);
    apply_stimulus(1, 0, 0, 1, '0);
    apply_stimulus(0, 0, 0, 1, '0);

    run_group('0);
    run_group(sat_pats[3]);
    run_group(sat_pats[0]);
    run_group(sat_pats[1]);
    run_group(sat_pats[2]);
    run_group(relu_pat);
    apply_stimulus(0, 0, 1, 1, sat_pats[3]);
    apply_stimulus(0, 0, 1, 1, sat_pats[3]);
    apply_stimulus(0, 0, 1, 1, sat_pats[3]);
    apply_stimulus(0, 0, 1, 1, relu_pat);

    // Backpressure: the group completes while downstream is stalled.
    for (int i = 0; i < ACC_LEN; i++) apply_stimulus(0, 0, 1, 0, sat_pats[i]);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1, 0, sat_pats[0]);
    for (int i = 0; i < ACC_LEN + 1; i++) apply_stimulus(0, 0, 1, 1, sat_pats[1]);

    apply_stimulus(0, 0, 1, 1, sat_pats[3]);
    apply_stimulus(0, 0, 1, 1, sat_pats[3]);
    apply_stimulus(0, 1, 1, 1, sat_pats[0]);
    run_group(sat_pats[3]);

    apply_stimulus(0, 0, 1, 0, sat_pats[0]);
    apply_stimulus(0, 0, 1, 0, sat_pats[0]);
    apply_stimulus(1, 0, 1, 0, sat_pats[0]);
    apply_stimulus(0, 0, 0, 1, '0);

    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0:       pat = 56'({$urandom, $urandom});
        1:       pat = 56'({$urandom, $urandom}) & 56'({$urandom, $urandom}) & 56'({$urandom, $urandom});
        2:       pat = sat_pats[$urandom_range(0, 3)];
        default: pat = relu_pat;
      endcase
      apply_stimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 5),
                     ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 70), pat);
    end

    for (int i = 0; i < ACC_LEN + 4; i++) apply_stimulus(0, 0, 0, 1, '0);
    @(negedge clk);
    #1;
    done = 1'b1;
    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
